// File: rtl/axi_hp_write_responder_if.sv
// rtl/axi_hp_write_responder_if.sv - AXI3 single-beat 64-bit write channel bundle (AW, W, B)
interface axi_hp_write_responder_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_hp_write_responder.sv
// rtl/axi_hp_write_responder.sv - single-beat AXI3 write responder into a local word RAM with readback
// Optional address checking with SLVERR responses is enabled by defining AXI_RESP_ADDR_CHECK_EN.
module axi_hp_write_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                       aclk,
  input  logic                       areset,
  axi_hp_write_responder_if.slave    s_axi,
  input  logic [DEPTH_LOG2-1:0]      rd_addr,
  output logic [63:0]                rd_data,
  output logic [31:0]                wr_count
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic                  aw_full;
  logic [31:0]           aw_addr;
  logic                  w_full;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  addr_ok;
  logic [1:0]            resp_nxt;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [63:0]           mem [DEPTH];

`ifdef AXI_RESP_ADDR_CHECK_EN
  logic [31:0] word_off;
  assign word_off = (aw_addr - BASE_ADDR) >> 3;
  assign word_idx = word_off[DEPTH_LOG2-1:0];
  assign addr_ok  = (aw_addr[2:0] == 3'b000) && (aw_addr >= BASE_ADDR) &&
                    (word_off[31:DEPTH_LOG2] == '0);
`else
  assign word_idx = DEPTH_LOG2'((aw_addr - BASE_ADDR) >> 3);
  assign addr_ok  = 1'b1;
`endif

  assign aw_hs    = s_axi.awvalid & s_axi.awready;
  assign w_hs     = s_axi.wvalid & s_axi.wready;
  // A pending response that is not being taken this edge blocks the next commit.
  assign commit   = aw_full & w_full & (~s_axi.bvalid | s_axi.bready);
  assign resp_nxt = addr_ok ? 2'b00 : 2'b10;
  assign mem_we   = commit & addr_ok & ~areset;

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full       <= 1'b0;
      aw_addr       <= '0;
      w_full        <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axi.awready <= 1'b1;
      s_axi.wready  <= 1'b1;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      wr_count      <= '0;
    end else begin
      if (commit) begin
        aw_full       <= 1'b0;
        s_axi.awready <= 1'b1;
      end else if (aw_hs) begin
        aw_full       <= 1'b1;
        aw_addr       <= s_axi.awaddr;
        s_axi.awready <= 1'b0;
      end

      if (commit) begin
        w_full       <= 1'b0;
        s_axi.wready <= 1'b1;
      end else if (w_hs) begin
        w_full       <= 1'b1;
        w_data       <= s_axi.wdata;
        w_strb       <= s_axi.wstrb;
        s_axi.wready <= 1'b0;
      end

      if (commit) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= resp_nxt;
        if (addr_ok) begin
          wr_count <= wr_count + 32'd1;
        end
      end else if (s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; only the byte lanes enabled by the strobe are written.
  always_ff @(posedge aclk) begin
    for (int k = 0; k < 8; k++) begin
      if (mem_we && w_strb[k]) begin
        mem[word_idx][8*k +: 8] <= w_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_axi_hp_write_responder.sv
// tb/tb_axi_hp_write_responder.sv - table-driven and scoreboard bench for axi_hp_write_responder
module tb_axi_hp_write_responder;
  localparam logic [31:0] B = 32'h1000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [9:0]  idx;
    logic [63:0] word;
  } vec_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] wr_count;

  axi_hp_write_responder_if bus ();

  axi_hp_write_responder #(.BASE_ADDR(B), .DEPTH_LOG2(10)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .s_axi   (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_count(wr_count)
  );

  always #5 aclk = ~aclk;

  int         nvec = 0;
  int         nmis = 0;
  int         b_seen = 0;
  int         exp_wr = 0;
  logic [1:0] exp_q[$];
  vec_t       vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!areset && bus.bvalid && bus.bready) begin
      b_seen++;
      if (exp_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
      else chk("bresp", {62'd0, bus.bresp}, {62'd0, exp_q.pop_front()});
    end
  end

  task automatic send_aw(input logic [31:0] a);
    bit done = 1'b0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge aclk);
      done = bus.awready;
      @(posedge aclk);
      #1;
    end
    bus.awvalid = 1'b0;
    if (!done) chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s);
    bit done = 1'b0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge aclk);
      done = bus.wready;
      @(posedge aclk);
      #1;
    end
    bus.wvalid = 1'b0;
    if (!done) chk("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_seen < target && n < 30) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (b_seen < target) chk("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic read_check(input string name, input logic [9:0] idx, input logic [63:0] exp);
    rd_addr = idx;
    @(posedge aclk);
    @(negedge aclk);
    chk(name, rd_data, exp);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [1:0] r);
    int target = b_seen + 1;
    exp_q.push_back(r);
    if (r == 2'b00) exp_wr++;
    fork
      send_aw(a);
      send_w(d, s);
    join
    wait_b(target);
  endtask

  initial begin
    vecs[0] = '{B + 32'd8,    64'hDEAD_BEEF_0123_4567, 8'hFF, 2'b00, 10'd1,    64'hDEAD_BEEF_0123_4567};
    vecs[1] = '{B + 32'd16,   64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 10'd2,    64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{B + 32'd16,   64'h0,                   8'h0F, 2'b00, 10'd2,    64'hFFFF_FFFF_0000_0000};
    vecs[3] = '{B + 32'd16,   64'h1122_3344_5566_7788, 8'h00, 2'b00, 10'd2,    64'hFFFF_FFFF_0000_0000};
    vecs[4] = '{B,            64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b00, 10'd0,    64'hA5A5_A5A5_A5A5_A5A5};
    vecs[5] = '{B + 32'd8184, 64'h0102_0304_0506_0708, 8'hFF, 2'b00, 10'd1023, 64'h0102_0304_0506_0708};
    vecs[6] = '{B + 32'd8184, 64'hF0F1_F2F3_F4F5_F6F7, 8'hA5, 2'b00, 10'd1023, 64'hF002_F204_05F5_07F7};
`ifdef AXI_RESP_ADDR_CHECK_EN
    vecs[7] = '{B + 32'd4,    64'h4444_4444_4444_4444, 8'hFF, 2'b10, 10'd0,    64'hA5A5_A5A5_A5A5_A5A5};
    vecs[8] = '{B + 32'd8192, 64'h8888_8888_8888_8888, 8'hFF, 2'b10, 10'd0,    64'hA5A5_A5A5_A5A5_A5A5};
    vecs[9] = '{B - 32'd8,    64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 2'b10, 10'd1023, 64'hF002_F204_05F5_07F7};
`else
    vecs[7] = '{B + 32'd4,    64'h4444_4444_4444_4444, 8'hFF, 2'b00, 10'd0,    64'h4444_4444_4444_4444};
    vecs[8] = '{B + 32'd8192, 64'h8888_8888_8888_8888, 8'hFF, 2'b00, 10'd0,    64'h8888_8888_8888_8888};
    vecs[9] = '{B - 32'd8,    64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 2'b00, 10'd1023, 64'h5A5A_5A5A_5A5A_5A5A};
`endif

    areset      = 1'b1;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    rd_addr     = '0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    @(negedge aclk);
    chk("rst_awready", bus.awready, 1);
    chk("rst_wready", bus.wready, 1);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_data", rd_data, 0);
    @(posedge aclk);
    #1;

    // Basic write: latency from the AW/W handshake to bvalid.
    exp_q.push_back(2'b00);
    exp_wr++;
    fork
      send_aw(B + 32'd8);
      send_w(64'hDEAD_BEEF_0123_4567, 8'hFF);
    join
    @(negedge aclk);
    chk("basic_bvalid_early", bus.bvalid, 0);
    chk("basic_awready_held", bus.awready, 0);
    chk("basic_wready_held", bus.wready, 0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("basic_bvalid", bus.bvalid, 1);
    chk("basic_awready_free", bus.awready, 1);
    chk("basic_wready_free", bus.wready, 1);
    @(posedge aclk);
    #1;
    read_check("basic_rd", 10'd1, 64'hDEAD_BEEF_0123_4567);
    chk("basic_wr_count", wr_count, 1);

    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      read_check($sformatf("vec%0d_rd", i), vecs[i].idx, vecs[i].word);
      chk($sformatf("vec%0d_wr_count", i), wr_count, exp_wr);
    end

    // W arrives three cycles before AW.
    exp_q.push_back(2'b00);
    exp_wr++;
    send_w(64'hC0FF_EE00_1122_3344, 8'hFF);
    repeat (3) begin
      @(negedge aclk);
      chk("ord_wready", bus.wready, 0);
      chk("ord_awready", bus.awready, 1);
      chk("ord_bvalid", bus.bvalid, 0);
      @(posedge aclk);
      #1;
    end
    send_aw(B + 32'd40);
    @(negedge aclk);
    chk("ord_bvalid_early", bus.bvalid, 0);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("ord_bvalid", bus.bvalid, 1);
    @(posedge aclk);
    #1;
    read_check("ord_rd", 10'd5, 64'hC0FF_EE00_1122_3344);

    // B backpressure with a second write held behind the first response.
    begin
      int t0 = b_seen;
      bus.bready = 1'b0;
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      fork
        send_aw(B + 32'd48);
        send_w(64'h6666_0000_6666_0000, 8'hFF);
      join
      @(posedge aclk);
      #1;
      exp_wr++;
      fork
        send_aw(B + 32'd56);
        send_w(64'h7777_1111_7777_1111, 8'hFF);
      join
      repeat (5) begin
        @(negedge aclk);
        chk("bp_bvalid", bus.bvalid, 1);
        chk("bp_bresp", bus.bresp, 0);
        chk("bp_awready", bus.awready, 0);
        chk("bp_wready", bus.wready, 0);
        chk("bp_wr_count", wr_count, exp_wr);
        @(posedge aclk);
        #1;
      end
      bus.bready = 1'b1;
      exp_wr++;
      @(posedge aclk);
      #1;
      @(negedge aclk);
      chk("bp_bvalid_second", bus.bvalid, 1);
      chk("bp_awready_free", bus.awready, 1);
      chk("bp_wready_free", bus.wready, 1);
      chk("bp_wr_count_second", wr_count, exp_wr);
      @(posedge aclk);
      #1;
      wait_b(t0 + 2);
      read_check("bp_rd_first", 10'd6, 64'h6666_0000_6666_0000);
      read_check("bp_rd_second", 10'd7, 64'h7777_1111_7777_1111);
    end

    // Reset while AW is held and W has not been sent.
    do_write(B + 32'd64, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'b00);
    send_aw(B + 32'd64);
    @(negedge aclk);
    chk("mid_awready_held", bus.awready, 0);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_awready", bus.awready, 1);
    chk("mid_wready", bus.wready, 1);
    chk("mid_bvalid", bus.bvalid, 0);
    chk("mid_wr_count", wr_count, 0);
    @(posedge aclk);
    #1;
    send_w(64'h0, 8'hFF);
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("mid_bvalid_after_w", bus.bvalid, 0);
    chk("mid_wr_count_after_w", wr_count, 0);
    @(posedge aclk);
    #1;
    read_check("mid_rd", 10'd8, 64'h1234_5678_9ABC_DEF0);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
